// File: rtl/lcd_text_buffer.sv
// Two-line, 16-column character frame buffer feeding the text LCD driver.
// Accepts ASCII/control codes, tracks a cursor and flags content changes.
module lcd_text_buffer #(
    parameter bit         WRAP      = 1'b1,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_char,
    output logic       in_ready,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       upd_req,
    input  logic       upd_ack,
    output logic [4:0] cursor_pos
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] clr_cnt_q, clr_cnt_d;
    logic [4:0] cursor_q, cursor_d;
    logic       upd_req_q, upd_req_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic [7:0] mem_q [32];

    logic       we;
    logic [4:0] waddr;
    logic [7:0] wdata;
    logic       set_upd;
    logic       is_print;

    assign is_print = (in_char >= 8'h20) && (in_char <= 8'h7E);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        cursor_d  = cursor_q;
        we        = 1'b0;
        waddr     = clr_cnt_q;
        wdata     = FILL_CHAR;
        set_upd   = 1'b0;
        rd_data_d = mem_q[rd_addr];

        case (state_q)
            S_CLEAR: begin
                we        = 1'b1;
                waddr     = clr_cnt_q;
                clr_cnt_d = clr_cnt_q + 5'd1;
                if (clr_cnt_q == 5'd31) begin
                    state_d   = S_IDLE;
                    clr_cnt_d = 5'd0;
                    set_upd   = 1'b1;
                end
            end
            S_IDLE: begin
                if (in_valid) begin
                    if (is_print) begin
                        we      = 1'b1;
                        waddr   = cursor_q;
                        wdata   = in_char;
                        set_upd = 1'b1;
                        if (cursor_q == 5'd31) begin
                            cursor_d = WRAP ? 5'd0 : 5'd31;
                        end else begin
                            cursor_d = cursor_q + 5'd1;
                        end
                    end else begin
                        case (in_char)
                            8'h0A: cursor_d = cursor_q[4] ? 5'd0 : 5'd16;
                            8'h0D: cursor_d = cursor_q[4] ? 5'd16 : 5'd0;
                            8'h08: begin
                                if (cursor_q != 5'd0) begin
                                    cursor_d = cursor_q - 5'd1;
                                    we       = 1'b1;
                                    waddr    = cursor_q - 5'd1;
                                    wdata    = FILL_CHAR;
                                    set_upd  = 1'b1;
                                end
                            end
                            8'h0C: begin
                                cursor_d  = 5'd0;
                                clr_cnt_d = 5'd0;
                                state_d   = S_CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase

        // A new modification outranks an acknowledge in the same cycle.
        upd_req_d = (upd_req_q && !upd_ack) || set_upd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= 5'd0;
            cursor_q  <= 5'd0;
            upd_req_q <= 1'b0;
            rd_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            cursor_q  <= cursor_d;
            upd_req_q <= upd_req_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign rd_data    = rd_data_q;
    assign upd_req    = upd_req_q;
    assign cursor_pos = cursor_q;

endmodule

// File: doc/lcd_text_buffer.md
Name: lcd_text_buffer

Overview:
Two-line, 16-column character frame buffer that sits directly upstream of the text LCD driver. It accepts a stream of ASCII characters and control codes over a valid/ready interface, maintains a cursor, and stores the 32 display cells. The LCD driver reads cells through a registered read port and uses a request/acknowledge pair to learn when the contents have changed.

Parameters:
WRAP, 1, 1 = cursor wraps from cell 31 to cell 0; 0 = cursor saturates at cell 31 and later printables overwrite cell 31.
FILL_CHAR, 8'h20, value written to every cell by a clear and by backspace.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-low reset.
in_valid  input  1  in_char holds a character or control code.
in_char  input  8  ASCII character or control code.
in_ready  output  1  buffer can accept in_char this cycle.
rd_addr  input  5  cell index from the LCD driver: 0-15 = line 1, 16-31 = line 2.
rd_data  output  8  cell contents, one-cycle latency.
upd_req  output  1  buffer contents changed since the last acknowledge.
upd_ack  input  1  single-cycle pulse from the driver at the start of a refresh.
cursor_pos  output  5  current cursor cell index.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=CLEAR, clr_cnt=0, cursor_pos=0.
  - in_ready=0, rd_data=8'h00, upd_req=0.
  - The cell array is not reset directly.
- CLEAR state:
  - Writes FILL_CHAR to cell clr_cnt once per clock, for 32 clocks (clr_cnt 0..31).
  - After the write to cell 31: go to IDLE, set upd_req=1, clr_cnt=0.
  - in_ready=0 throughout CLEAR.
  - The first clock after reset release writes cell 0.
- IDLE state: in_ready=1 (registered, equal to state==IDLE). A transfer occurs when in_valid and in_ready are both 1 on a rising edge. At most one code is processed per clock.
- Printable character (8'h20-8'h7E):
  - Write in_char to cell cursor_pos.
  - Advance cursor: 15 goes to 16. At 31, go to 0 if WRAP=1; stay at 31 if WRAP=0.
  - Set upd_req.
- 8'h0A newline: cursor_pos becomes 16 if it is below 16, otherwise 0. No cell write. upd_req unchanged.
- 8'h0D carriage return: cursor_pos becomes 0 if it is below 16, otherwise 16. No cell write.
- 8'h08 backspace:
  - If cursor_pos>0: cursor_pos-1, write FILL_CHAR to the new cursor cell, set upd_req.
  - If cursor_pos=0: no operation.
- 8'h0C form feed: cursor_pos becomes 0 and state becomes CLEAR. in_ready drops to 0 on the next clock for 32 clocks.
- Any other code (other values <8'h20, and 8'h7F-8'hFF): consumed and ignored. No cursor change, no write.
- Read port:
  - rd_data <= cell[rd_addr] on every clock, in any state.
  - Read-before-write: a same-cycle write to rd_addr returns the old value, and the new value appears one clock later.
- upd_req:
  - Set by any cell modification or by CLEAR completion.
  - Cleared by upd_ack.
  - If a modification and upd_ack occur in the same cycle, upd_req stays 1 (set wins).
  - upd_ack while upd_req=0 has no effect.
- Reset mid-operation: any in-progress CLEAR or character write is abandoned, and a full 32-cycle CLEAR restarts after rst deasserts.
- Cursor arithmetic is 5-bit, and no cell index outside 0..31 exists.

Test Plan:
- Reset release:
  - ready must rise exactly 32 clocks after release (clocks 1-31 low), upd_req=1 at the same time.
  - Reading addresses 0-31 returns 8'h20 each, one clock after the address is applied.
- Stream "HELLO" (48 45 4C 4C 4F) back-to-back:
  - Cells 0-4 hold those codes, cursor_pos=5, upd_req=1.
  - Pulse upd_ack: upd_req=0.
- 17 printables starting at cursor 0: the 16th lands in cell 15 and the 17th in cell 16; cursor_pos=17.
- With cursor_pos=3: send 0x0A, expect cursor=16; send 0x0D, expect 16; send 0x0A, expect 0. Then send 0x08 at cursor 0: no change, no upd_req.
- WRAP=1, cursor=31, write 'A': cell31=8'h41, cursor=0. WRAP=0, same stimulus: cursor stays 31, and a following 'B' overwrites cell31=8'h42.
- Send 0x0C after "HI":
  - in_ready=0 for 32 clocks; afterwards all cells are 8'h20, cursor=0, upd_req=1.
  - Assert rst at clear clock 10: clear restarts and ready rises 32 clocks after release.
  - Printable write and upd_ack in the same cycle: upd_req remains 1.
